// File: rtl/lrn_window_buffer.sv
// LRN channel-window stage: captures one pixel's channels, runs the cross-channel sum of squares
// and issues dividend/divisor pairs to the divider. Define LRN_DIV_SATURATE_EN to saturate the divisor.
module lrn_window_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int M_WIDTH     = 10,
  parameter int DEPTH       = 64,
  parameter int LOCAL_SIZE  = 5,
  parameter int RD_LATENCY  = 2,
  parameter int ALPHA_SHIFT = 8,
  parameter int K_CONST     = 1
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  start_normalization,
  input  logic [M_WIDTH-1:0]    dim3,
  input  logic                  r_enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full_flag,
  output logic                  div_in_valid,
  input  logic                  div_in_ready,
  output logic [DATA_WIDTH-1:0] dividend,
  output logic [DATA_WIDTH-1:0] divisor,
  input  logic                  div_out_valid,
  output logic                  normalized_window,
  output logic                  overflow_err
);
  localparam int HALF  = LOCAL_SIZE / 2;
  localparam int SUM_W = 2 * DATA_WIDTH + $clog2(LOCAL_SIZE + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {S_FILL, S_PRIME, S_UPD, S_LOAD, S_WAIT, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [RD_LATENCY-1:0] cap_sr_q, cap_sr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         issue_ptr_q, issue_ptr_d;
  logic [PW-1:0]         ret_cnt_q, ret_cnt_d;
  logic [SUM_W-1:0]      run_sum_q, run_sum_d;
  logic                  full_flag_q, full_flag_d;
  logic                  div_in_valid_q, div_in_valid_d;
  logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
  logic                  normalized_window_q, normalized_window_d;
  logic                  overflow_err_q, overflow_err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [AW-1:0]         mem_wa;

  logic                  cap_v;
  logic [PW-1:0]         n_ch;
  logic [31:0]           c_idx, add_idx, prime_lim;
  logic [AW-1:0]         sub_idx;
  logic                  add_ok, sub_ok;
  logic [DATA_WIDTH-1:0] div_val;

  function automatic logic [SUM_W-1:0] sq(input logic [DATA_WIDTH-1:0] x);
    logic [SUM_W-1:0] xe;
    xe = SUM_W'(x);
    return xe * xe;
  endfunction

  assign cap_v     = cap_sr_q[RD_LATENCY-1];
  assign n_ch      = (dim3 > M_WIDTH'(DEPTH)) ? PW'(DEPTH) : PW'(dim3);
  assign c_idx     = 32'(issue_ptr_q);
  assign add_idx   = c_idx + 32'(HALF);
  assign sub_idx   = AW'(c_idx - 32'(HALF) - 32'd1);
  assign add_ok    = add_idx < 32'(n_ch);
  assign sub_ok    = c_idx >= 32'(HALF) + 32'd1;
  assign prime_lim = (32'(HALF) < 32'(n_ch)) ? 32'(HALF) : 32'(n_ch);

  // Divisor never drives zero so the divider can never see a divide-by-zero.
  always_comb begin
`ifdef LRN_DIV_SATURATE_EN
    logic [SUM_W:0] div_full;
    div_full = (SUM_W + 1)'(K_CONST) + {1'b0, run_sum_q >> ALPHA_SHIFT};
    if (|div_full[SUM_W:DATA_WIDTH]) div_val = '1;
    else                             div_val = div_full[DATA_WIDTH-1:0];
`else
    div_val = DATA_WIDTH'(K_CONST) + DATA_WIDTH'(run_sum_q >> ALPHA_SHIFT);
`endif
    if (div_val == '0) div_val = DATA_WIDTH'(1);
  end

  always_comb begin
    state_d             = state_q;
    cap_sr_d            = cap_sr_q << 1;
    cap_sr_d[0]         = r_enable;
    wr_ptr_d            = wr_ptr_q;
    issue_ptr_d         = issue_ptr_q;
    ret_cnt_d           = ret_cnt_q;
    run_sum_d           = run_sum_q;
    full_flag_d         = full_flag_q;
    div_in_valid_d      = div_in_valid_q;
    dividend_d          = dividend_q;
    divisor_d           = divisor_q;
    normalized_window_d = normalized_window_q;
    overflow_err_d      = overflow_err_q;
    mem_we              = 1'b0;
    mem_wa              = wr_ptr_q[AW-1:0];

    if (cap_v) begin
      if (state_q == S_FILL) begin
        if (wr_ptr_q < n_ch) begin
          mem_we              = 1'b1;
          wr_ptr_d            = wr_ptr_q + 1'b1;
          normalized_window_d = 1'b0;
        end
      end else begin
        overflow_err_d = 1'b1;
      end
    end

    if (div_out_valid && (state_q inside {S_UPD, S_LOAD, S_WAIT, S_DRAIN}))
      ret_cnt_d = ret_cnt_q + 1'b1;

    case (state_q)
      S_FILL: begin
        if (n_ch != '0 && wr_ptr_q == n_ch) begin
          full_flag_d = 1'b1;
          issue_ptr_d = '0;
          state_d     = S_PRIME;
        end
      end
      S_PRIME: begin
        if (c_idx < prime_lim)
          run_sum_d = run_sum_q + sq(mem_q[issue_ptr_q[AW-1:0]]);
        if (c_idx + 32'd1 >= prime_lim) begin
          issue_ptr_d = '0;
          state_d     = S_UPD;
        end else begin
          issue_ptr_d = issue_ptr_q + 1'b1;
        end
      end
      // Slide the window: bring in channel c+HALF, retire channel c-HALF-1.
      S_UPD: begin
        run_sum_d = run_sum_q
                  + (add_ok ? sq(mem_q[add_idx[AW-1:0]]) : '0)
                  - (sub_ok ? sq(mem_q[sub_idx]) : '0);
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        dividend_d     = mem_q[issue_ptr_q[AW-1:0]];
        divisor_d      = div_val;
        div_in_valid_d = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (div_in_ready) begin
          div_in_valid_d = 1'b0;
          issue_ptr_d    = issue_ptr_q + 1'b1;
          state_d        = (c_idx + 32'd1 >= 32'(n_ch)) ? S_DRAIN : S_UPD;
        end
      end
      S_DRAIN: begin
        if (ret_cnt_q >= n_ch) begin
          normalized_window_d = 1'b1;
          full_flag_d         = 1'b0;
          wr_ptr_d            = '0;
          issue_ptr_d         = '0;
          ret_cnt_d           = '0;
          run_sum_d           = '0;
          state_d             = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    if (start_normalization) begin
      state_d             = S_FILL;
      cap_sr_d            = '0;
      wr_ptr_d            = '0;
      issue_ptr_d         = '0;
      ret_cnt_d           = '0;
      run_sum_d           = '0;
      full_flag_d         = 1'b0;
      div_in_valid_d      = 1'b0;
      dividend_d          = '0;
      divisor_d           = '0;
      normalized_window_d = 1'b0;
      overflow_err_d      = 1'b0;
      mem_we              = 1'b0;
    end
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q             <= S_FILL;
      cap_sr_q            <= '0;
      wr_ptr_q            <= '0;
      issue_ptr_q         <= '0;
      ret_cnt_q           <= '0;
      run_sum_q           <= '0;
      full_flag_q         <= 1'b0;
      div_in_valid_q      <= 1'b0;
      dividend_q          <= '0;
      divisor_q           <= '0;
      normalized_window_q <= 1'b0;
      overflow_err_q      <= 1'b0;
    end else begin
      state_q             <= state_d;
      cap_sr_q            <= cap_sr_d;
      wr_ptr_q            <= wr_ptr_d;
      issue_ptr_q         <= issue_ptr_d;
      ret_cnt_q           <= ret_cnt_d;
      run_sum_q           <= run_sum_d;
      full_flag_q         <= full_flag_d;
      div_in_valid_q      <= div_in_valid_d;
      dividend_q          <= dividend_d;
      divisor_q           <= divisor_d;
      normalized_window_q <= normalized_window_d;
      overflow_err_q      <= overflow_err_d;
    end
  end

  always_ff @(posedge core_clk) begin
    if (mem_we) mem_q[mem_wa] <= rd_data;
  end

  assign full_flag         = full_flag_q;
  assign div_in_valid      = div_in_valid_q;
  assign dividend          = dividend_q;
  assign divisor           = divisor_q;
  assign normalized_window = normalized_window_q;
  assign overflow_err      = overflow_err_q;
endmodule

// File: tb/tb_lrn_window_buffer.sv
// Scoreboard bench for lrn_window_buffer: windows are modelled as plain sums of squares over
// the clipped channel neighbourhood; a monitor pops expected pairs on every divider handshake.
module tb_lrn_window_buffer;
  localparam int DW    = 16;
  localparam int MW    = 10;
  localparam int DEPTH = 8;
  localparam int LS    = 5;
  localparam int HALF  = LS / 2;
  localparam int RDL   = 2;
  localparam int SHIFT = 0;
  localparam int KC    = 1;

  logic          core_clk = 1'b0;
  logic          reset, start_normalization, r_enable, div_in_ready, div_out_valid;
  logic [MW-1:0] dim3;
  logic [DW-1:0] rd_data, dividend, divisor;
  logic          full_flag, div_in_valid, normalized_window, overflow_err;

  always #5 core_clk = ~core_clk;

  lrn_window_buffer #(
    .DATA_WIDTH(DW), .M_WIDTH(MW), .DEPTH(DEPTH), .LOCAL_SIZE(LS),
    .RD_LATENCY(RDL), .ALPHA_SHIFT(SHIFT), .K_CONST(KC)
  ) dut (
    .core_clk(core_clk), .reset(reset), .start_normalization(start_normalization),
    .dim3(dim3), .r_enable(r_enable), .rd_data(rd_data), .full_flag(full_flag),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready), .dividend(dividend),
    .divisor(divisor), .div_out_valid(div_out_valid),
    .normalized_window(normalized_window), .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [DW-1:0] dvd;
    logic [DW-1:0] dvs;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            pending = 0;
  int            win_hs = 0;
  int            stall_c = -1;
  int            stall_left = 0;
  bit            ready_rand = 0;
  bit            ready_hold = 0;
  bit            expect_norm = 0;
  logic [DW-1:0] win_data [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_div(input longint s);
    longint t;
    t = longint'(KC) + (s >>> SHIFT);
`ifdef LRN_DIV_SATURATE_EN
    if (t > (longint'(1) << DW) - 1) t = (longint'(1) << DW) - 1;
`else
    t = t % (longint'(1) << DW);
`endif
    if (t == 0) t = 1;
    return DW'(t);
  endfunction

  // Expected pair for channel c: x[c] over K + sum of x[j]^2, j in [c-HALF, c+HALF] clipped to [0,n).
  task automatic push_expected(input int n);
    for (int c = 0; c < n; c++) begin
      longint s;
      exp_t   e;
      s = 0;
      for (int j = c - HALF; j <= c + HALF; j++)
        if (j >= 0 && j < n) s += longint'(win_data[j]) * longint'(win_data[j]);
      e.dvd = win_data[c];
      e.dvs = model_div(s);
      sb.push_back(e);
    end
  endtask

  task automatic read_word(input logic [DW-1:0] d);
    r_enable = 1'b1;
    @(posedge core_clk); #1;
    r_enable = 1'b0;
    @(posedge core_clk); #1;
    rd_data = d;
    @(posedge core_clk); #1;
  endtask

  task automatic run_window(input int dimv, input bit lat_chk, input bit extra);
    int n;
    int k;
    n = (dimv > DEPTH) ? DEPTH : dimv;
    dim3 = MW'(dimv);
    win_hs = 0;
    push_expected(n);
    if (expect_norm) check("norm_hold", normalized_window, 1);
    for (int i = 0; i < n; i++) begin
      read_word(win_data[i]);
      if (i == 0 && expect_norm) check("norm_clear", normalized_window, 0);
    end
    if (extra) begin
      read_word(16'h0063);
      check("ovf_set", overflow_err, 1);
    end else if (lat_chk) begin
      check("full_early", full_flag, 0);
      @(posedge core_clk); #1;
      check("full_lat", full_flag, 1);
      k = 0;
      while (!div_in_valid && k < 20) begin
        @(posedge core_clk); #1;
        k++;
      end
      check("valid_lat", 64'(k), 64'(HALF + 2));
    end
    k = 0;
    while (!normalized_window && k < 400) begin
      @(posedge core_clk); #1;
      k++;
    end
    check("norm_set", normalized_window, 1);
    check("full_clr", full_flag, 0);
    check("sb_empty", 64'(sb.size()), 0);
    check(extra ? "ovf_sticky" : "ovf_clean", overflow_err, 64'(extra));
    expect_norm = 1;
  endtask

  task automatic pulse_start();
    start_normalization = 1'b1;
    @(posedge core_clk); #1;
    start_normalization = 1'b0;
  endtask

  // Monitor: scoreboard pop on handshake, stability check while stalled.
  initial begin
    bit            held;
    logic [DW-1:0] h_dvd, h_dvs;
    exp_t          e;
    held = 0;
    forever begin
      @(negedge core_clk);
      if (reset) begin
        held = 0;
        continue;
      end
      if (held) begin
        check("hold_valid", div_in_valid, 1);
        check("hold_dividend", dividend, h_dvd);
        check("hold_divisor", divisor, h_dvs);
        held = 0;
      end
      if (div_in_valid && div_in_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hs: dividend=%0d divisor=%0d with empty scoreboard", dividend, divisor);
        end else begin
          e = sb.pop_front();
          check("dividend", dividend, e.dvd);
          check("divisor", divisor, e.dvs);
        end
        pending++;
        win_hs++;
      end else if (div_in_valid) begin
        held  = 1;
        h_dvd = dividend;
        h_dvs = divisor;
      end
    end
  end

  // Divider model: one return pulse per accepted pair, after a random delay.
  initial begin
    forever begin
      @(posedge core_clk); #1;
      if (!reset && pending > 0 && $urandom_range(0, 1) == 1) begin
        div_out_valid = 1'b1;
        pending--;
      end else begin
        div_out_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge core_clk); #1;
      if (ready_hold) div_in_ready = 1'b0;
      else if (stall_left > 0 && div_in_valid && win_hs == stall_c) begin
        div_in_ready = 1'b0;
        stall_left--;
      end else if (ready_rand) div_in_ready = ($urandom_range(0, 3) != 0);
      else div_in_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    start_normalization = 1'b0;
    r_enable = 1'b0;
    rd_data = '0;
    dim3 = '0;
    div_in_ready = 1'b1;
    div_out_valid = 1'b0;
    repeat (2) @(posedge core_clk);
    #1;
    check("rst_full", full_flag, 0);
    check("rst_valid", div_in_valid, 0);
    check("rst_dividend", dividend, 0);
    check("rst_divisor", divisor, 0);
    check("rst_norm", normalized_window, 0);
    check("rst_ovf", overflow_err, 0);
    reset = 1'b0;
    @(posedge core_clk); #1;

    // Basic window 1,2,3,4 then the same window with c=1 stalled for 3 cycles.
    for (int i = 0; i < 4; i++) win_data[i] = DW'(i + 1);
    run_window(4, 1, 0);
    stall_c = 1;
    stall_left = 3;
    run_window(4, 1, 0);
    stall_c = -1;

    // All-ones data: exercises divisor wrap or saturation.
    for (int i = 0; i < 5; i++) win_data[i] = 16'hFFFF;
    run_window(5, 1, 0);

    // Window sum of 65535 at c=1: K+sum crosses exactly into bit 16.
    win_data[0] = 16'd255; win_data[1] = 16'd22; win_data[2] = 16'd5; win_data[3] = 16'd1;
    run_window(4, 0, 0);

    // dim3 above DEPTH is clipped; single-channel window.
    for (int i = 0; i < 10; i++) win_data[i] = DW'($urandom_range(0, 300));
    run_window(10, 0, 0);
    win_data[0] = 16'd77;
    run_window(1, 0, 0);

    ready_rand = 1;
    for (int w = 0; w < 6; w++) begin
      k = $urandom_range(1, 12);
      for (int i = 0; i < 12; i++)
        win_data[i] = (w % 2 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 65535));
      run_window(k, 0, 0);
    end
    ready_rand = 0;

    // Extra capture after the window is full: dropped and flagged until start_normalization.
    for (int i = 0; i < 3; i++) win_data[i] = DW'(10 * (i + 1));
    run_window(3, 0, 1);
    pulse_start();
    check("ovf_clr", overflow_err, 0);
    check("norm_clr_start", normalized_window, 0);
    expect_norm = 0;

    // dim3 == 0 never completes.
    dim3 = '0;
    read_word(16'd5);
    read_word(16'd6);
    repeat (10) @(posedge core_clk);
    #1;
    check("dim0_full", full_flag, 0);
    check("dim0_valid", div_in_valid, 0);
    check("dim0_ovf", overflow_err, 0);
    pulse_start();

    // Reset mid-ISSUE, then refill of dim3=3.
    ready_hold = 1;
    dim3 = MW'(4);
    for (int i = 0; i < 4; i++) read_word(DW'(i + 5));
    k = 0;
    while (!div_in_valid && k < 40) begin
      @(posedge core_clk); #1;
      k++;
    end
    check("rst_reach_issue", div_in_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_full", full_flag, 0);
    check("mid_rst_valid", div_in_valid, 0);
    check("mid_rst_dividend", dividend, 0);
    check("mid_rst_divisor", divisor, 0);
    check("mid_rst_norm", normalized_window, 0);
    check("mid_rst_ovf", overflow_err, 0);
    sb.delete();
    pending = 0;
    repeat (2) @(posedge core_clk);
    #1;
    reset = 1'b0;
    ready_hold = 0;
    expect_norm = 0;
    for (int i = 0; i < 3; i++) win_data[i] = DW'(9 + i);
    run_window(3, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
